// File: rtl/lane_distributor_pkg.sv
// Shared link-layer definitions used by the lane distributor and its aggregator peer.
package lane_distributor_pkg;

    // Default lane geometry, common to both ends of the link
    localparam int DEFAULT_NUM_LANES  = 4;
    localparam int DEFAULT_LANE_WIDTH = 32;

    // Width needed to hold an occupancy count from 0 up to depth inclusive
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Low bit index of a lane's slice inside a wide flit (lane 0 in the LSBs)
    function automatic int slice_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/lane_distributor_fifo.sv
// Single-lane first-word-fall-through FIFO. The head entry is always presented on
// data_o while the FIFO is non-empty; pushes into a full FIFO and pops from an
// empty one are ignored.
module lane_fifo
    import lane_distributor_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int CW    = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_next_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Empty lanes present zero so nothing stale leaks out after a reset
    assign data_o       = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_next_o = count_d;

    // Next occupancy: simultaneous push and pop leaves the count unchanged
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy state; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Slice storage; contents are only meaningful where the count says so
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/lane_distributor.sv
// Stripes each accepted wide flit across NUM_LANES independent FWFT lane FIFOs and
// reports the occupancy spread between the fullest and emptiest lane.
module lane_distributor
    import lane_distributor_pkg::*;
#(
    parameter  int NUM_LANES  = DEFAULT_NUM_LANES,
    parameter  int LANE_WIDTH = DEFAULT_LANE_WIDTH,
    parameter  int FIFO_DEPTH = 4,
    localparam int CW         = count_width(FIFO_DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    input  logic [NUM_LANES*LANE_WIDTH-1:0] in_data,
    output logic                            in_ready,
    output logic [NUM_LANES-1:0]            lane_valid,
    output logic [NUM_LANES*LANE_WIDTH-1:0] lane_data,
    input  logic [NUM_LANES-1:0]            lane_ready,
    output logic [CW-1:0]                   lane_skew
);

    logic [NUM_LANES-1:0] full;
    logic [NUM_LANES-1:0] empty;
    logic [CW-1:0]        cnt_d [NUM_LANES];
    logic                 push;
    logic                 rdy_en_q;
    logic [CW-1:0]        max_d;
    logic [CW-1:0]        min_d;
    logic [CW-1:0]        skew_q;

    // A flit is accepted only when every lane has room, so it is never split
    assign in_ready   = rdy_en_q && !(|full);
    assign push       = in_valid && in_ready;
    assign lane_valid = ~empty;
    assign lane_skew  = skew_q;

    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            lane_fifo #(
                .WIDTH (LANE_WIDTH),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk          (clk),
                .rst_n        (rst_n),
                .push_i       (push),
                .pop_i        (lane_ready[i]),
                .data_i       (in_data[slice_lo(i, LANE_WIDTH) +: LANE_WIDTH]),
                .data_o       (lane_data[slice_lo(i, LANE_WIDTH) +: LANE_WIDTH]),
                .count_next_o (cnt_d[i]),
                .full_o       (full[i]),
                .empty_o      (empty[i])
            );
        end
    endgenerate

    // Holds in_ready low while reset is asserted; opens on the first edge after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_en_q <= 1'b0;
        else        rdy_en_q <= 1'b1;
    end

    // Max/min over the next-state lane counts
    always_comb begin
        max_d = '0;
        min_d = CW'(FIFO_DEPTH);
        for (int l = 0; l < NUM_LANES; l++) begin
            if (cnt_d[l] > max_d) max_d = cnt_d[l];
            if (cnt_d[l] < min_d) min_d = cnt_d[l];
        end
    end

    // Registered skew so it lines up with the counts it describes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) skew_q <= '0;
        else        skew_q <= max_d - min_d;
    end

endmodule

// File: tb/tb_lane_distributor.sv
// Testbench for lane_distributor: directed stimulus with a per-lane scoreboard.
module tb_lane_distributor;

    localparam int NL = 4;
    localparam int LW = 32;
    localparam int FD = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [NL*LW-1:0]  in_data;
    logic              in_ready;
    logic [NL-1:0]     lane_valid;
    logic [NL*LW-1:0]  lane_data;
    logic [NL-1:0]     lane_ready;
    logic [2:0]        lane_skew;

    int checks = 0;
    int fails  = 0;
    int k;
    int hs_cnt;
    logic hs;
    logic [LW-1:0] exp_q [NL][$];

    always #5 clk = ~clk;

    lane_distributor #(
        .NUM_LANES  (NL),
        .LANE_WIDTH (LW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .lane_valid (lane_valid),
        .lane_data  (lane_data),
        .lane_ready (lane_ready),
        .lane_skew  (lane_skew)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Flit k: lane i slice = {A0+i, k}
    function automatic logic [NL*LW-1:0] flit(input int n);
        logic [NL*LW-1:0] f;
        for (int i = 0; i < NL; i++) begin
            f[i*LW +: LW] = {8'(8'hA0 + i), 24'(n)};
        end
        return f;
    endfunction

    // Scoreboard: pop/compare on lane handshakes, push on input handshakes
    always @(negedge clk) begin
        logic [LW-1:0] e;
        if (!rst_n) begin
            for (int i = 0; i < NL; i++) exp_q[i].delete();
        end else begin
            for (int i = 0; i < NL; i++) begin
                if (lane_valid[i] && lane_ready[i]) begin
                    checks++;
                    if (exp_q[i].size() == 0) begin
                        fails++;
                        $display("FAIL lane%0d_unexpected: got %h expected no output", i, lane_data[i*LW +: LW]);
                    end else begin
                        e = exp_q[i].pop_front();
                        if (lane_data[i*LW +: LW] !== e) begin
                            fails++;
                            $display("FAIL lane%0d_data: got %h expected %h", i, lane_data[i*LW +: LW], e);
                        end
                    end
                end
            end
            if (in_valid && in_ready) begin
                for (int i = 0; i < NL; i++) exp_q[i].push_back(in_data[i*LW +: LW]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with in_valid asserted
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        in_data    = flit(99);
        lane_ready = '1;
        tick();
        tick();
        check("rst_in_ready",   128'(in_ready),   128'(1'b0));
        check("rst_lane_valid", 128'(lane_valid), 128'(4'b0000));
        check("rst_skew",       128'(lane_skew),  128'(3'd0));
        check("rst_lane_data",  128'(lane_data),  128'(0));
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        check("post_rst_in_ready", 128'(in_ready), 128'(1'b1));

        // Single flit, all lanes ready
        in_valid = 1'b1;
        in_data  = 128'h44444444_33333333_22222222_11111111;
        tick();
        in_valid = 1'b0;
        check("single_valid", 128'(lane_valid), 128'(4'b1111));
        check("single_data",  128'(lane_data),  128'h44444444_33333333_22222222_11111111);
        tick();
        check("single_drained", 128'(lane_valid), 128'(4'b0000));
        check("single_skew",    128'(lane_skew),  128'(3'd0));

        // Lane 1 stalled: it fills after four flits
        lane_ready = 4'b1101;
        k = 0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_data  = flit(k);
            hs = in_ready;
            tick();
            if (hs) k++;
        end
        check("stall_accepted", 128'(k),         128'(4));
        check("stall_in_ready", 128'(in_ready),  128'(1'b0));
        check("stall_skew3",    128'(lane_skew), 128'(3'd3));
        in_data = flit(4);
        tick();
        check("stall_in_ready2", 128'(in_ready),   128'(1'b0));
        check("stall_skew4",     128'(lane_skew),  128'(3'd4));
        check("stall_valid",     128'(lane_valid), 128'(4'b0010));
        check("stall_head",      128'(lane_data[LW +: LW]), 128'(32'hA1000000));

        // Full lane popped while a push is pending: push lands one cycle later
        lane_ready = 4'b1111;
        tick();
        check("fullpop_in_ready", 128'(in_ready),   128'(1'b1));
        check("fullpop_valid",    128'(lane_valid), 128'(4'b0010));
        check("fullpop_head",     128'(lane_data[LW +: LW]), 128'(32'hA1000001));
        check("fullpop_skew",     128'(lane_skew),  128'(3'd3));
        tick();
        in_valid = 1'b0;
        check("fullpop_push_valid", 128'(lane_valid), 128'(4'b1111));
        check("fullpop_push_lane0", 128'(lane_data[LW-1:0]), 128'(32'hA0000004));
        check("fullpop_push_lane1", 128'(lane_data[LW +: LW]), 128'(32'hA1000002));
        check("fullpop_push_skew",  128'(lane_skew), 128'(3'd2));
        repeat (5) tick();
        check("drain_valid", 128'(lane_valid), 128'(4'b0000));
        check("drain_skew",  128'(lane_skew),  128'(3'd0));

        // 100 back-to-back flits at full rate
        hs_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            in_valid = 1'b1;
            in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (in_ready) hs_cnt++;
            tick();
        end
        in_valid = 1'b0;
        check("b2b_handshakes", 128'(hs_cnt), 128'(100));
        repeat (3) tick();

        // Random stalls, then a mid-stream reset
        for (int c = 0; c < 40; c++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_data    = {$urandom(), $urandom(), $urandom(), $urandom()};
            lane_ready = 4'($urandom());
            tick();
        end
        lane_ready = 4'b0000;
        in_valid   = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_valid",    128'(lane_valid), 128'(4'b0000));
        check("midrst_skew",     128'(lane_skew),  128'(3'd0));
        check("midrst_in_ready", 128'(in_ready),   128'(1'b0));
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        for (int c = 0; c < 40; c++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_data    = {$urandom(), $urandom(), $urandom(), $urandom()};
            lane_ready = 4'($urandom());
            tick();
        end
        in_valid   = 1'b0;
        lane_ready = 4'b1111;
        repeat (8) tick();
        check("final_valid", 128'(lane_valid), 128'(4'b0000));
        check("final_skew",  128'(lane_skew),  128'(3'd0));
        for (int i = 0; i < NL; i++) begin
            check($sformatf("final_queue%0d", i), 128'(exp_q[i].size()), 128'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
